// File: rtl/au_op_sequencer_pkg.sv
// Shared types and constants for the arithmetic-unit operation sequencer.
package au_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MULT = 2'b10,
        OP_DIV  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic is_zero(input logic [31:0] hi, input logic [31:0] lo);
        return ~|{hi, lo};
    endfunction

endpackage

// File: rtl/au_op_sequencer_if.sv
// Command, AU and response signals of the sequencer; slave = sequencer side.
interface au_op_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [31:0] au_a;
    logic [31:0] au_b;
    logic [1:0]  au_op;
    logic [31:0] au_s;
    logic [31:0] au_hi;
    logic [31:0] au_lo;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_zero;
    logic        rsp_dz;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, au_s, au_hi, au_lo, rsp_ready,
        output cmd_ready, au_a, au_b, au_op, rsp_valid, rsp_op, rsp_hi, rsp_lo,
               rsp_zero, rsp_dz, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, au_s, au_hi, au_lo, rsp_ready,
        input  cmd_ready, au_a, au_b, au_op, rsp_valid, rsp_op, rsp_hi, rsp_lo,
               rsp_zero, rsp_dz, busy
    );
endinterface

// File: rtl/au_op_sequencer_lat_counter.sv
// Loadable down-counter; tc is high while the count is 1 (last wait cycle).
module au_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/au_op_sequencer.sv
// Issues one op to the AU, holds operands for the fixed op latency, returns one response.
module au_op_sequencer
    import au_seq_pkg::*;
#(
    parameter int ADDSUB_LAT = 1,
    parameter int MULDIV_LAT = 33,
    parameter int CNT_W      = 6
) (
    input logic             clk,
    input logic             rst_n,
    au_op_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] ADDSUB_CNT = CNT_W'(ADDSUB_LAT);
    localparam logic [CNT_W-1:0] MULDIV_CNT = CNT_W'(MULDIV_LAT);

    state_t      state_q, state_d;
    logic [31:0] au_a_q, au_a_d, au_b_q, au_b_d;
    logic [1:0]  au_op_q, au_op_d, rsp_op_q, rsp_op_d;
    logic [31:0] rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
    logic        rsp_zero_q, rsp_zero_d, rsp_dz_q, rsp_dz_d;
    logic        cnt_load, cnt_tc;
    logic [CNT_W-1:0] cnt_val;
    logic [31:0] cap_hi, cap_lo;

    au_lat_counter #(.CNT_W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    // ADD/SUB return only s; MULT/DIV return the full hi/lo pair.
    assign cap_hi  = au_op_q[1] ? bus.au_hi : 32'd0;
    assign cap_lo  = au_op_q[1] ? bus.au_lo : bus.au_s;
    assign cnt_val = bus.cmd_op[1] ? MULDIV_CNT : ADDSUB_CNT;

    always_comb begin
        state_d    = state_q;
        au_a_d     = au_a_q;
        au_b_d     = au_b_q;
        au_op_d    = au_op_q;
        rsp_op_d   = rsp_op_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_lo_d   = rsp_lo_q;
        rsp_zero_d = rsp_zero_q;
        rsp_dz_d   = rsp_dz_q;
        cnt_load   = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                au_a_d  = bus.cmd_a;
                au_b_d  = bus.cmd_b;
                au_op_d = bus.cmd_op;
                // Divide-by-zero is answered locally without waiting on the AU.
                if (bus.cmd_op == OP_DIV && bus.cmd_b == 32'd0) begin
                    rsp_op_d   = OP_DIV;
                    rsp_hi_d   = bus.cmd_a;
                    rsp_lo_d   = DZ_QUOTIENT;
                    rsp_zero_d = 1'b0;
                    rsp_dz_d   = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: if (cnt_tc) begin
                rsp_op_d   = au_op_q;
                rsp_hi_d   = cap_hi;
                rsp_lo_d   = cap_lo;
                rsp_zero_d = is_zero(cap_hi, cap_lo);
                rsp_dz_d   = 1'b0;
                state_d    = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            au_a_q     <= '0;
            au_b_q     <= '0;
            au_op_q    <= '0;
            rsp_op_q   <= '0;
            rsp_hi_q   <= '0;
            rsp_lo_q   <= '0;
            rsp_zero_q <= 1'b0;
            rsp_dz_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            au_a_q     <= au_a_d;
            au_b_q     <= au_b_d;
            au_op_q    <= au_op_d;
            rsp_op_q   <= rsp_op_d;
            rsp_hi_q   <= rsp_hi_d;
            rsp_lo_q   <= rsp_lo_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_dz_q   <= rsp_dz_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.au_a      = au_a_q;
    assign bus.au_b      = au_b_q;
    assign bus.au_op     = au_op_q;
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_lo    = rsp_lo_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_dz    = rsp_dz_q;
endmodule

// File: tb/tb_au_op_sequencer.sv
// Scoreboard bench for au_op_sequencer with a behavioural AU attached.
module tb_au_op_sequencer;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        dz;
    } exp_t;

    exp_t sb[$];

    au_op_sequencer_if bus ();

    au_op_sequencer #(.ADDSUB_LAT(1), .MULDIV_LAT(33), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural AU: combinational results from the held operands.
    logic [63:0] prod;
    always_comb begin
        prod       = {32'd0, bus.au_a} * {32'd0, bus.au_b};
        bus.au_s   = bus.au_op[0] ? bus.au_a - bus.au_b : bus.au_a + bus.au_b;
        bus.au_hi  = 32'd0;
        bus.au_lo  = 32'd0;
        if (bus.au_op == 2'b10) begin
            bus.au_hi = prod[63:32];
            bus.au_lo = prod[31:0];
        end else if (bus.au_op == 2'b11 && bus.au_b != 32'd0) begin
            bus.au_hi = bus.au_a % bus.au_b;
            bus.au_lo = bus.au_a / bus.au_b;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Response monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_op", bus.rsp_op, e.op);
                chk("rsp_hi", bus.rsp_hi, e.hi);
                chk("rsp_lo", bus.rsp_lo, e.lo);
                chk("rsp_zero", bus.rsp_zero, e.zero);
                chk("rsp_dz", bus.rsp_dz, e.dz);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = ~a;
        bus.cmd_b     = ~b;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic ez, input logic edz, input int lat);
        int n;
        bit held;
        exp_t e;
        e.op = op; e.hi = ehi; e.lo = elo; e.zero = ez; e.dz = edz;
        sb.push_back(e);
        issue(op, a, b);
        held = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            if (bus.cmd_ready || bus.au_a !== a || bus.au_b !== b || bus.au_op !== op || !bus.busy)
                held = 1'b0;
            @(posedge clk); #1; n++;
        end
        chk("latency", n, lat);
        chk("held", held, 1);
    endtask

    initial begin
        bit stable;
        int n;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 32'd0;
        bus.cmd_b     = 32'd0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_au_a", {bus.au_a, bus.au_b}, 64'd0);
        chk("rst_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        chk("rst_flags", {bus.au_op, bus.rsp_op, bus.rsp_zero, bus.rsp_dz}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);

        run_op(2'b00, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1'b0, 1);
        run_op(2'b01, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1);
        run_op(2'b10, 32'h10000, 32'h10000, 32'd1, 32'd0, 1'b0, 1'b0, 33);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 33);
        run_op(2'b11, 32'd123, 32'd0, 32'd123, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);

        // Backpressure: response held while a competing command is offered.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        run_op(2'b00, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, 1'b0, 1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'b01;
            bus.cmd_a     = 32'd77;
            bus.cmd_b     = 32'd3;
            @(posedge clk); #1;
            if (!bus.rsp_valid || bus.rsp_lo !== 32'd2 || bus.rsp_hi !== 32'd0 ||
                bus.cmd_ready || bus.au_a !== 32'd1 || bus.rsp_op !== 2'b00)
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", bus.rsp_valid, 0);
        @(posedge clk); #1;
        chk("bp_no_accept", bus.busy, 0);

        // Reset during a MULT aborts it with no response.
        issue(2'b10, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.rsp_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_au", {bus.au_a, bus.au_b}, 64'd0);
        chk("mid_rst_rsp", {bus.rsp_hi, bus.rsp_lo, bus.rsp_op, bus.au_op}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", bus.cmd_ready, 1);
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) n++;
        end
        chk("no_rsp_after_abort", n, 0);

        // Wraparound add yields zero.
        run_op(2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
